// File: rtl/kb_code_ctrl.sv
// kb_code_ctrl: PS/2 scan-code decoder.
// Tracks break/extended prefixes, shift and caps-lock state, suppresses
// typematic repeats and presents decoded make codes through a valid/ready
// holding register with a sticky overflow flag.
module kb_code_ctrl #(
    parameter logic DROP_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       scan_done_tick,
    output logic [8:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       caps_lock,
    output logic       overflow
);

    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t      state_r;
    logic        lshift_r;
    logic        rshift_r;
    logic        caps_held_r;
    logic        caps_lock_r;
    logic [7:0]  last_make_r;
    logic [8:0]  key_code_r;
    logic        key_valid_r;
    logic        overflow_r;

    logic        shift_eff_s;
    logic        is_modifier_s;
    logic        is_repeat_s;
    logic        emit_s;
    logic        load_s;
    logic        drop_s;

    // Letter keys are the only codes whose case follows caps lock.
    function automatic logic is_letter(input logic [7:0] code);
        logic hit;
        case (code)
            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
            8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
            8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
            8'h35, 8'h1A: hit = 1'b1;
            default:      hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Decide whether the current byte produces a key and whether it fits.
    always_comb begin
        shift_eff_s   = (lshift_r | rshift_r) ^ (caps_lock_r & is_letter(scan_code));
        is_modifier_s = (scan_code == CODE_LSHIFT) || (scan_code == CODE_RSHIFT) ||
                        (scan_code == CODE_CAPS);
        is_repeat_s   = DROP_REPEAT && (scan_code == last_make_r);
        emit_s        = 1'b0;
        load_s        = 1'b0;
        drop_s        = 1'b0;
        if (scan_done_tick && (state_r == ST_IDLE) &&
            (scan_code != CODE_BRK) && (scan_code != CODE_EXT) &&
            !is_modifier_s && !is_repeat_s) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end
        if (emit_s) begin
            load_s = !key_valid_r || key_ready;
            drop_s = key_valid_r && !key_ready;
        end else begin
            load_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Prefix FSM together with modifier and repeat-filter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            lshift_r    <= 1'b0;
            rshift_r    <= 1'b0;
            caps_held_r <= 1'b0;
            caps_lock_r <= 1'b0;
            last_make_r <= 8'h00;
        end else if (scan_done_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (scan_code == CODE_BRK) begin
                        state_r <= ST_BRK;
                    end else if (scan_code == CODE_EXT) begin
                        state_r <= ST_EXT;
                    end else begin
                        state_r <= ST_IDLE;
                        case (scan_code)
                            CODE_LSHIFT: lshift_r <= 1'b1;
                            CODE_RSHIFT: rshift_r <= 1'b1;
                            CODE_CAPS: begin
                                // Held caps key repeats must not re-toggle.
                                if (!caps_held_r) begin
                                    caps_lock_r <= ~caps_lock_r;
                                    caps_held_r <= 1'b1;
                                end
                            end
                            default: begin
                                if (load_s) begin
                                    last_make_r <= scan_code;
                                end
                            end
                        endcase
                    end
                end
                ST_BRK: begin
                    state_r     <= ST_IDLE;
                    last_make_r <= 8'h00;
                    case (scan_code)
                        CODE_LSHIFT: lshift_r    <= 1'b0;
                        CODE_RSHIFT: rshift_r    <= 1'b0;
                        CODE_CAPS:   caps_held_r <= 1'b0;
                        default:     ;
                    endcase
                end
                ST_EXT: begin
                    if (scan_code == CODE_BRK) begin
                        state_r <= ST_EXT_BRK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    state_r     <= ST_IDLE;
                    last_make_r <= 8'h00;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Output holding register with valid/ready handshake and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code_r  <= 9'h000;
            key_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (load_s) begin
                key_code_r  <= {shift_eff_s, scan_code};
                key_valid_r <= 1'b1;
            end else if (key_ready) begin
                key_valid_r <= 1'b0;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign caps_lock = caps_lock_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_kb_code_ctrl.sv
// tb_kb_code_ctrl: directed scenarios plus random byte streams, checked
// every cycle against a behavioural keyboard model.
module tb_kb_code_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       scan_done_tick = 1'b0;
    logic       key_ready = 1'b0;
    logic [8:0] key_code;
    logic       key_valid;
    logic       caps_lock;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic       m_f0, m_e0, m_ls, m_rs, m_caps, m_held, m_valid, m_ovf;
    logic [8:0] m_code;
    logic [7:0] m_last;

    logic [7:0] letters [0:25] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
        8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
        8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

    kb_code_ctrl #(.DROP_REPEAT(1'b1)) dut (
        .clk(clk), .rst(rst), .scan_code(scan_code),
        .scan_done_tick(scan_done_tick), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready),
        .caps_lock(caps_lock), .overflow(overflow)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    function automatic logic m_is_letter(input logic [7:0] c);
        for (int i = 0; i < 26; i++) begin
            if (letters[i] == c) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge's worth of inputs to the model.
    task automatic model_edge(input logic r, input logic t, input logic [7:0] c,
                              input logic rdy);
        logic emit, brk, ext;
        logic [8:0] cand;
        emit = 1'b0;
        cand = 9'h000;
        if (r) begin
            m_f0 = 1'b0; m_e0 = 1'b0; m_ls = 1'b0; m_rs = 1'b0;
            m_caps = 1'b0; m_held = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
            m_code = 9'h000; m_last = 8'h00;
            return;
        end
        if (t) begin
            if (!m_f0 && c == 8'hF0) begin
                m_f0 = 1'b1;
            end else if (!m_f0 && !m_e0 && c == 8'hE0) begin
                m_e0 = 1'b1;
            end else begin
                brk = m_f0; ext = m_e0;
                m_f0 = 1'b0; m_e0 = 1'b0;
                if (brk) begin
                    m_last = 8'h00;
                    if (!ext) begin
                        if (c == 8'h12) m_ls = 1'b0;
                        if (c == 8'h59) m_rs = 1'b0;
                        if (c == 8'h58) m_held = 1'b0;
                    end
                end else if (!ext) begin
                    if (c == 8'h12) m_ls = 1'b1;
                    else if (c == 8'h59) m_rs = 1'b1;
                    else if (c == 8'h58) begin
                        if (!m_held) begin m_caps = ~m_caps; m_held = 1'b1; end
                    end else if (c != m_last) begin
                        emit = 1'b1;
                        cand = {((m_ls | m_rs) ^ (m_caps & m_is_letter(c))), c};
                    end
                end
            end
        end
        if (emit) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1; m_code = cand; m_last = c;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic t, input logic [7:0] c,
                        input logic rdy);
        @(negedge clk);
        rst = r; scan_done_tick = t; scan_code = c; key_ready = rdy;
        @(posedge clk);
        model_edge(r, t, c, rdy);
        #1;
        chk("model_key_valid", {8'h00, key_valid}, {8'h00, m_valid});
        chk("model_key_code", key_code, m_code);
        chk("model_caps_lock", {8'h00, caps_lock}, {8'h00, m_caps});
        chk("model_overflow", {8'h00, overflow}, {8'h00, m_ovf});
    endtask

    task automatic tick(input logic [7:0] c, input logic rdy);
        step(1'b0, 1'b1, c, rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [7:0] pool [0:10] = '{8'hF0, 8'hE0, 8'h12, 8'h59, 8'h58, 8'h1C,
                                    8'h32, 8'h21, 8'h16, 8'h75, 8'h29};
        logic [31:0] rnd;
        logic [7:0]  c;

        do_reset();
        chk("reset_key_valid", {8'h00, key_valid}, 9'h000);
        chk("reset_key_code", key_code, 9'h000);
        chk("reset_caps", {8'h00, caps_lock}, 9'h000);
        chk("reset_overflow", {8'h00, overflow}, 9'h000);

        // Simple make, then release: one key only.
        tick(8'h1C, 1'b0);
        chk("make_1c_valid", {8'h00, key_valid}, 9'h001);
        chk("make_1c_code", key_code, 9'h01C);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        tick(8'hF0, 1'b1);
        tick(8'h1C, 1'b1);
        chk("release_no_key", {8'h00, key_valid}, 9'h000);

        // Shifted letter, then unshifted key after shift release.
        do_reset();
        tick(8'h12, 1'b1);
        tick(8'h1C, 1'b1);
        chk("shift_1c_code", key_code, 9'h11C);
        tick(8'hF0, 1'b1); tick(8'h1C, 1'b1);
        tick(8'hF0, 1'b1); tick(8'h12, 1'b1);
        tick(8'h16, 1'b1);
        chk("unshift_16_code", key_code, 9'h016);
        chk("unshift_16_valid", {8'h00, key_valid}, 9'h001);

        // Caps lock single toggle and interaction with shift.
        do_reset();
        tick(8'h58, 1'b1); tick(8'h58, 1'b1);
        tick(8'hF0, 1'b1); tick(8'h58, 1'b1);
        chk("caps_single_toggle", {8'h00, caps_lock}, 9'h001);
        tick(8'h1C, 1'b1);
        chk("caps_1c_code", key_code, 9'h11C);
        tick(8'hF0, 1'b1); tick(8'h1C, 1'b1);
        tick(8'h12, 1'b1); tick(8'h1C, 1'b1);
        chk("caps_shift_1c_code", key_code, 9'h01C);

        // Extended sequences discarded; repeats dropped.
        do_reset();
        tick(8'hE0, 1'b1); tick(8'h75, 1'b1);
        tick(8'hE0, 1'b1); tick(8'hF0, 1'b1); tick(8'h75, 1'b1);
        chk("ext_no_key", {8'h00, key_valid}, 9'h000);
        tick(8'h1C, 1'b1);
        chk("ext_then_idle_code", key_code, 9'h01C);
        chk("ext_then_idle_valid", {8'h00, key_valid}, 9'h001);
        tick(8'h1C, 1'b1);
        chk("repeat_dropped_1", {8'h00, key_valid}, 9'h000);
        tick(8'h1C, 1'b1);
        chk("repeat_dropped_2", {8'h00, key_valid}, 9'h000);

        // Overflow when consumer stalls.
        do_reset();
        tick(8'h1C, 1'b0); tick(8'hF0, 1'b0); tick(8'h1C, 1'b0); tick(8'h32, 1'b0);
        chk("ovf_hold_code", key_code, 9'h01C);
        chk("ovf_flag", {8'h00, overflow}, 9'h001);
        do_reset();
        tick(8'h1C, 1'b0);
        tick(8'h32, 1'b1);
        chk("ready_load_code", key_code, 9'h032);
        chk("ready_load_valid", {8'h00, key_valid}, 9'h001);
        chk("ready_load_no_ovf", {8'h00, overflow}, 9'h000);

        // Reset mid-sequence discards the break prefix.
        do_reset();
        tick(8'hF0, 1'b1);
        do_reset();
        tick(8'h1C, 1'b1);
        chk("rst_mid_code", key_code, 9'h01C);
        chk("rst_mid_valid", {8'h00, key_valid}, 9'h001);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rnd = $urandom;
            c = rnd[7:0];
            if ($urandom_range(0, 3) != 0) c = pool[$urandom_range(0, 10)];
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), c,
                 ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
